// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the
// data memory. The arbiter takes the slave view; the requesters/memory side
// (or a testbench standing in for them) takes the master view.
interface dm_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    // Port A (CPU)
    logic          req_a;
    logic          we_a;
    logic          lock_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] wdata_a;
    logic          gnt_a;
    logic          rvalid_a;
    logic [DW-1:0] rdata_a;

    // Port B (loader / debug)
    logic          req_b;
    logic          we_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] wdata_b;
    logic          gnt_b;
    logic          rvalid_b;
    logic [DW-1:0] rdata_b;

    // Data memory side
    logic [AW-1:0] dm_add;
    logic [DW-1:0] dm_in;
    logic          dm_we;
    logic          dm_re;
    logic [DW-1:0] dm_out;

    // Contention statistics
    logic [15:0]   conflict_cnt;

    modport slave (
        input  req_a, we_a, lock_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        input  dm_out,
        output gnt_a, rvalid_a, rdata_a,
        output gnt_b, rvalid_b, rdata_b,
        output dm_add, dm_in, dm_we, dm_re,
        output conflict_cnt
    );

    modport master (
        output req_a, we_a, lock_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        output dm_out,
        input  gnt_a, rvalid_a, rdata_a,
        input  gnt_b, rvalid_b, rdata_b,
        input  dm_add, dm_in, dm_we, dm_re,
        input  conflict_cnt
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter. Port A (CPU) and port B (loader/debug) share
// one single-port memory with one-cycle read latency. Contention is resolved
// round-robin; port A may lock the memory across a read-modify-write so that
// port B cannot slip in between the read and the write-back.
module dm_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    dm_arbiter_if.slave  bus
);

    typedef enum logic { ARB, LOCK_A } state_e;
    typedef enum logic { PORT_A, PORT_B } port_e;

    state_e        state_q, state_d;
    port_e         last_gnt_q, last_gnt_d;
    logic          rvalid_a_q, rvalid_a_d;
    logic          rvalid_b_q, rvalid_b_d;
    logic [15:0]   conflict_cnt_q, conflict_cnt_d;

    logic          gnt_a, gnt_b;
    logic [AW-1:0] dm_add;
    logic [DW-1:0] dm_in;
    logic          dm_we, dm_re;

    // Grant selection, lock tracking and round-robin pointer update
    // NOTE: every signal written here gets a default first, so no path through the block can infer a latch.
    always_comb begin
        gnt_a      = 1'b0;
        gnt_b      = 1'b0;
        state_d    = state_q;
        last_gnt_d = last_gnt_q;

        // Nothing is issued to memory during the reset cycle.
        if (rst_n) begin
            case (state_q)
                ARB: begin
                    if (bus.req_a && bus.req_b) begin
                        gnt_a = (last_gnt_q == PORT_B);
                        gnt_b = !gnt_a;
                    end else begin
                        gnt_a = bus.req_a;
                        gnt_b = bus.req_b;
                    end
                end
                LOCK_A: begin
                    // B stays blocked even while A is idle mid-sequence.
                    gnt_a = bus.req_a;
                end
                default: ;
            endcase

            if (gnt_a) begin
                last_gnt_d = PORT_A;
            end else if (gnt_b) begin
                last_gnt_d = PORT_B;
            end

            // Each A grant decides whether A keeps the memory afterwards.
            if (gnt_a) begin
                state_d = bus.lock_a ? LOCK_A : ARB;
            end
        end
    end

    // Steer the granted port's command onto the memory interface
    always_comb begin
        dm_add = '0;
        dm_in  = '0;
        dm_we  = 1'b0;
        dm_re  = 1'b0;
        if (gnt_a) begin
            dm_add = bus.addr_a;
            dm_in  = bus.wdata_a;
            dm_we  = bus.we_a;
            dm_re  = !bus.we_a;
        end else if (gnt_b) begin
            dm_add = bus.addr_b;
            dm_in  = bus.wdata_b;
            dm_we  = bus.we_b;
            dm_re  = !bus.we_b;
        end
    end

    // Read-return tracking and saturating conflict counter
    always_comb begin
        rvalid_a_d     = gnt_a && !bus.we_a;
        rvalid_b_d     = gnt_b && !bus.we_b;
        conflict_cnt_d = conflict_cnt_q;
        if (bus.req_a && bus.req_b && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    // State registers with synchronous active-low reset
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ARB;
            last_gnt_q     <= PORT_B;
            rvalid_a_q     <= 1'b0;
            rvalid_b_q     <= 1'b0;
            conflict_cnt_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            last_gnt_q     <= last_gnt_d;
            rvalid_a_q     <= rvalid_a_d;
            rvalid_b_q     <= rvalid_b_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign bus.gnt_a        = gnt_a;
    assign bus.gnt_b        = gnt_b;
    assign bus.dm_add       = dm_add;
    assign bus.dm_in        = dm_in;
    assign bus.dm_we        = dm_we;
    assign bus.dm_re        = dm_re;
    assign bus.rvalid_a     = rvalid_a_q;
    assign bus.rvalid_b     = rvalid_b_q;
    assign bus.rdata_a      = rvalid_a_q ? bus.dm_out : '0;
    assign bus.rdata_b      = rvalid_b_q ? bus.dm_out : '0;
    assign bus.conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios for reset, read
// latency, conflicts, write-then-read ordering, locking and saturation, plus
// a randomized run checked against a transaction-level reference model.
module tb_dm_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    dm_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dm_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory: writes land at the grant edge, read
    // data appears the cycle after dm_re.
    logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: '0};
    initial bus.dm_out = '0;
    always @(posedge clk) begin
        if (bus.dm_we) mem[bus.dm_add] <= bus.dm_in;
        if (bus.dm_re) bus.dm_out <= mem[bus.dm_add];
    end

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive_a(input logic req, input logic we, input logic lock,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bus.req_a   = req;
        bus.we_a    = we;
        bus.lock_a  = lock;
        bus.addr_a  = addr;
        bus.wdata_a = wdata;
    endtask

    task automatic drive_b(input logic req, input logic we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bus.req_b   = req;
        bus.we_b    = we;
        bus.addr_b  = addr;
        bus.wdata_b = wdata;
    endtask

    task automatic idle();
        drive_a(1'b0, 1'b0, 1'b0, '0, '0);
        drive_b(1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst_n = 1'b0;
        drive_a(1'b1, 1'b0, 1'b0, 10'd4, '0);
        drive_b(1'b1, 1'b1, 10'd6, 32'h1111_2222);
        sample();
        tests_run++;
        if ({bus.gnt_a, bus.gnt_b, bus.dm_we, bus.dm_re} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_cycle_quiet: gnt_a,gnt_b,dm_we,dm_re=%b expected 0000",
                     {bus.gnt_a, bus.gnt_b, bus.dm_we, bus.dm_re});
        end
        tick();
        rst_n = 1'b1;
        idle();
        sample();
        tests_run++;
        if ({bus.conflict_cnt, bus.rvalid_a, bus.rvalid_b, bus.rdata_a, bus.rdata_b} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: cnt=%h rvalid_a=%b rvalid_b=%b rdata_a=%h rdata_b=%h expected all zero",
                     bus.conflict_cnt, bus.rvalid_a, bus.rvalid_b, bus.rdata_a, bus.rdata_b);
        end
        tick();
    endtask

    task automatic test_single_read();
        drive_b(1'b1, 1'b1, 10'd1, 32'd1);
        sample();
        tests_run++;
        if ({bus.gnt_a, bus.gnt_b, bus.dm_we, bus.dm_re, bus.dm_add, bus.dm_in} !==
            {4'b0110, 10'd1, 32'd1}) begin
            tests_failed++;
            $display("FAIL single_read_setup_write: gnt/we/re=%b add=%h in=%h expected 0110 add=1 in=1",
                     {bus.gnt_a, bus.gnt_b, bus.dm_we, bus.dm_re}, bus.dm_add, bus.dm_in);
        end
        tick();
        idle();
        drive_a(1'b1, 1'b0, 1'b0, 10'd1, '0);
        sample();
        tests_run++;
        if ({bus.gnt_a, bus.gnt_b, bus.dm_we, bus.dm_re, bus.dm_add} !== {4'b1001, 10'd1}) begin
            tests_failed++;
            $display("FAIL single_read_grant: gnt/we/re=%b add=%h expected 1001 add=1",
                     {bus.gnt_a, bus.gnt_b, bus.dm_we, bus.dm_re}, bus.dm_add);
        end
        tick();
        idle();
        sample();
        tests_run++;
        if ({bus.rvalid_a, bus.rvalid_b, bus.rdata_a} !== {2'b10, 32'd1}) begin
            tests_failed++;
            $display("FAIL single_read_data: rvalid_a=%b rvalid_b=%b rdata_a=%h expected 1 0 00000001",
                     bus.rvalid_a, bus.rvalid_b, bus.rdata_a);
        end
        tick();
        sample();
        tests_run++;
        if ({bus.rvalid_a, bus.rdata_a} !== {1'b0, 32'd0}) begin
            tests_failed++;
            $display("FAIL single_read_one_shot: rvalid_a=%b rdata_a=%h expected 0 0",
                     bus.rvalid_a, bus.rdata_a);
        end
        tick();
    endtask

    task automatic test_conflict();
        logic [DW-1:0] val;
        logic          exp_a;
        logic [1:0]    exp_rv;
        val = 32'hA5A5_0002;
        drive_b(1'b1, 1'b1, 10'd2, val);
        tick();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive_a(1'b1, 1'b0, 1'b0, 10'd2, '0);
            drive_b(1'b1, 1'b0, 10'd2, '0);
            exp_a  = (k % 2 == 0);
            exp_rv = (k == 0) ? 2'b00 : {!exp_a, exp_a};
            sample();
            tests_run++;
            if ({bus.gnt_a, bus.gnt_b} !== {exp_a, !exp_a}) begin
                tests_failed++;
                $display("FAIL conflict_grant[%0d]: gnt_a,gnt_b=%b expected %b",
                         k, {bus.gnt_a, bus.gnt_b}, {exp_a, !exp_a});
            end
            tests_run++;
            if ({bus.rvalid_a, bus.rvalid_b, bus.rdata_a, bus.rdata_b} !==
                {exp_rv, (exp_rv[1] ? val : 32'd0), (exp_rv[0] ? val : 32'd0)}) begin
                tests_failed++;
                $display("FAIL conflict_rvalid[%0d]: rvalid=%b rdata_a=%h rdata_b=%h expected rvalid=%b",
                         k, {bus.rvalid_a, bus.rvalid_b}, bus.rdata_a, bus.rdata_b, exp_rv);
            end
            tick();
        end
        idle();
        sample();
        tests_run++;
        if ({bus.conflict_cnt, bus.rvalid_a, bus.rvalid_b, bus.rdata_b} !== {16'd4, 2'b01, val}) begin
            tests_failed++;
            $display("FAIL conflict_count: cnt=%0d rvalid=%b rdata_b=%h expected 4 01 %h",
                     bus.conflict_cnt, {bus.rvalid_a, bus.rvalid_b}, bus.rdata_b, val);
        end
        tick();
    endtask

    task automatic test_write_then_read();
        drive_b(1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF);
        sample();
        tests_run++;
        if ({bus.gnt_b, bus.dm_we, bus.dm_add, bus.dm_in} !== {2'b11, 10'd5, 32'hDEAD_BEEF}) begin
            tests_failed++;
            $display("FAIL wtr_write: gnt_b=%b dm_we=%b add=%h in=%h expected 1 1 5 deadbeef",
                     bus.gnt_b, bus.dm_we, bus.dm_add, bus.dm_in);
        end
        tick();
        idle();
        drive_a(1'b1, 1'b0, 1'b0, 10'd5, '0);
        sample();
        tests_run++;
        if ({bus.gnt_a, bus.dm_re, bus.dm_add} !== {2'b11, 10'd5}) begin
            tests_failed++;
            $display("FAIL wtr_read_grant: gnt_a=%b dm_re=%b add=%h expected 1 1 5",
                     bus.gnt_a, bus.dm_re, bus.dm_add);
        end
        tick();
        idle();
        sample();
        tests_run++;
        if ({bus.rvalid_a, bus.rdata_a} !== {1'b1, 32'hDEAD_BEEF}) begin
            tests_failed++;
            $display("FAIL wtr_read_data: rvalid_a=%b rdata_a=%h expected 1 deadbeef",
                     bus.rvalid_a, bus.rdata_a);
        end
        tick();
    endtask

    task automatic test_lock();
        do_reset();
        // Locked read by A; B requests throughout.
        drive_a(1'b1, 1'b0, 1'b1, 10'd3, '0);
        drive_b(1'b1, 1'b0, 10'd7, '0);
        sample();
        tests_run++;
        if ({bus.gnt_a, bus.gnt_b} !== 2'b10) begin
            tests_failed++;
            $display("FAIL lock_first_grant: gnt_a,gnt_b=%b expected 10", {bus.gnt_a, bus.gnt_b});
        end
        tick();
        // A idles for two cycles; B must stay blocked.
        for (int k = 0; k < 2; k++) begin
            drive_a(1'b0, 1'b0, 1'b0, '0, '0);
            sample();
            tests_run++;
            if ({bus.gnt_a, bus.gnt_b, bus.dm_we, bus.dm_re} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL lock_blocks_b[%0d]: gnt/we/re=%b expected 0000",
                         k, {bus.gnt_a, bus.gnt_b, bus.dm_we, bus.dm_re});
            end
            tick();
        end
        // Unlocking write-back.
        drive_a(1'b1, 1'b1, 1'b0, 10'd3, 32'h0000_1234);
        sample();
        tests_run++;
        if ({bus.gnt_a, bus.gnt_b, bus.dm_we} !== 3'b101) begin
            tests_failed++;
            $display("FAIL lock_release_write: gnt_a,gnt_b,dm_we=%b expected 101",
                     {bus.gnt_a, bus.gnt_b, bus.dm_we});
        end
        tick();
        drive_a(1'b0, 1'b0, 1'b0, '0, '0);
        sample();
        tests_run++;
        if ({bus.gnt_a, bus.gnt_b, bus.dm_re, bus.dm_add} !== {3'b011, 10'd7}) begin
            tests_failed++;
            $display("FAIL lock_b_after_release: gnt_a,gnt_b,dm_re=%b add=%h expected 011 7",
                     {bus.gnt_a, bus.gnt_b, bus.dm_re}, bus.dm_add);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_reset_mid_lock();
        drive_a(1'b1, 1'b0, 1'b1, 10'd3, '0);
        sample();
        tests_run++;
        if (bus.gnt_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL midlock_enter: gnt_a=%b expected 1", bus.gnt_a);
        end
        tick();
        rst_n = 1'b0;
        drive_b(1'b1, 1'b0, 10'd7, '0);
        sample();
        tests_run++;
        if ({bus.gnt_a, bus.gnt_b, bus.dm_we, bus.dm_re} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midlock_reset_cycle: gnt/we/re=%b expected 0000",
                     {bus.gnt_a, bus.gnt_b, bus.dm_we, bus.dm_re});
        end
        tick();
        rst_n = 1'b1;
        drive_a(1'b0, 1'b0, 1'b0, '0, '0);
        sample();
        tests_run++;
        if ({bus.gnt_a, bus.gnt_b, bus.rvalid_a, bus.conflict_cnt} !== {3'b010, 16'd0}) begin
            tests_failed++;
            $display("FAIL midlock_after_reset: gnt_a,gnt_b,rvalid_a=%b cnt=%0d expected 010 0",
                     {bus.gnt_a, bus.gnt_b, bus.rvalid_a}, bus.conflict_cnt);
        end
        tick();
        idle();
        tick();
    endtask

    function automatic logic [DW-1:0] ref_read(input logic [DW-1:0] m [int], input int k);
        return m.exists(k) ? m[k] : '0;
    endfunction

    task automatic test_random();
        logic [DW-1:0] ref_mem [int];
        bit            pa = 0, pb = 0;
        logic          wa = 0, la = 0, wb = 0;
        logic [AW-1:0] aa = '0, ab = '0;
        logic [DW-1:0] da = '0, db = '0;
        bit            locked = 0;
        bit            last_was_a = 0;
        int            cnt = 0;
        bit            ea, eb;
        bit            rv_a = 0, rv_b = 0;
        logic [DW-1:0] rd_a = '0, rd_b = '0;
        logic [1+1+AW+DW-1:0] exp_cmd;
        int            errs = 0;

        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!pa && $urandom_range(0, 99) < 60) begin
                pa = 1; wa = 1'($urandom_range(0, 1)); la = ($urandom_range(0, 3) == 0);
                aa = AW'(16 + $urandom_range(0, 7)); da = $urandom;
            end
            if (!pb && $urandom_range(0, 99) < 60) begin
                pb = 1; wb = 1'($urandom_range(0, 1));
                ab = AW'(16 + $urandom_range(0, 7)); db = $urandom;
            end
            drive_a(pa, wa, la, aa, da);
            drive_b(pb, wb, ab, db);

            // A locked memory belongs to A; otherwise a lone requester wins and a
            // tie goes to whichever port did not win most recently.
            if (locked)        begin ea = pa; eb = 0; end
            else if (pa && pb) begin ea = !last_was_a; eb = last_was_a; end
            else               begin ea = pa; eb = pb; end

            if (ea)      exp_cmd = {wa, !wa, aa, da};
            else if (eb) exp_cmd = {wb, !wb, ab, db};
            else         exp_cmd = '0;

            sample();
            tests_run++;
            if ({bus.gnt_a, bus.gnt_b} !== {ea, eb} ||
                {bus.dm_we, bus.dm_re, bus.dm_add, bus.dm_in} !== exp_cmd) begin
                tests_failed++; errs++;
                if (errs < 10)
                    $display("FAIL rand_grant[%0d]: gnt=%b cmd=%h expected gnt=%b cmd=%h",
                             cyc, {bus.gnt_a, bus.gnt_b},
                             {bus.dm_we, bus.dm_re, bus.dm_add, bus.dm_in}, {ea, eb}, exp_cmd);
            end
            tests_run++;
            if ({bus.rvalid_a, bus.rdata_a, bus.rvalid_b, bus.rdata_b} !== {rv_a, rd_a, rv_b, rd_b}) begin
                tests_failed++; errs++;
                if (errs < 10)
                    $display("FAIL rand_read[%0d]: rv_a=%b rd_a=%h rv_b=%b rd_b=%h expected %b %h %b %h",
                             cyc, bus.rvalid_a, bus.rdata_a, bus.rvalid_b, bus.rdata_b,
                             rv_a, rd_a, rv_b, rd_b);
            end
            tests_run++;
            if (bus.conflict_cnt !== 16'(cnt)) begin
                tests_failed++; errs++;
                if (errs < 10)
                    $display("FAIL rand_conflict_cnt[%0d]: got %0d expected %0d", cyc, bus.conflict_cnt, cnt);
            end

            if (pa && pb && cnt < 65535) cnt++;
            rv_a = ea && !wa;
            rv_b = eb && !wb;
            rd_a = rv_a ? ref_read(ref_mem, int'(aa)) : '0;
            rd_b = rv_b ? ref_read(ref_mem, int'(ab)) : '0;
            if (ea) begin
                if (wa) ref_mem[int'(aa)] = da;
                locked = la; last_was_a = 1; pa = 0;
            end else if (eb) begin
                if (wb) ref_mem[int'(ab)] = db;
                last_was_a = 0; pb = 0;
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        drive_a(1'b1, 1'b0, 1'b0, '0, '0);
        drive_b(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 65534; i++) @(posedge clk);
        sample();
        tests_run++;
        if (bus.conflict_cnt !== 16'hFFFE) begin
            tests_failed++;
            $display("FAIL sat_before: cnt=%h expected fffe", bus.conflict_cnt);
        end
        @(posedge clk);
        sample();
        tests_run++;
        if (bus.conflict_cnt !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL sat_reach: cnt=%h expected ffff", bus.conflict_cnt);
        end
        for (int i = 0; i < 5; i++) @(posedge clk);
        #1;
        idle();
        sample();
        tests_run++;
        if (bus.conflict_cnt !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL sat_hold: cnt=%h expected ffff", bus.conflict_cnt);
        end
        tick();
    endtask

    // -------------------------------------------------------------- sequence
    initial begin
        idle();
        rst_n = 1'b0;
        tick();
        test_reset();
        test_single_read();
        test_conflict();
        test_write_then_read();
        test_lock();
        test_reset_mid_lock();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "timeout");
    end

endmodule
